// File: rtl/stk_pipe_wrbk.sv
// Memory/writeback stage of the stack pipeline.
// Carries lookup microcode across the data-SRAM read latency, captures the
// popped line, and emits registered writeback microcode plus a pop response.
// A per-engine in-flight counter lets lookup stall commands that would hazard.
module stk_pipe_wrbk #(
    parameter int ENGS_N   = 4,
    parameter int BANKS_N  = 4,
    parameter int PTR_W    = 8,
    parameter int MEM_LAT  = 1,
    parameter int ENGID_W  = (ENGS_N  > 1) ? $clog2(ENGS_N)  : 1,
    parameter int BANKID_W = (BANKS_N > 1) ? $clog2(BANKS_N) : 1,
    parameter int CNT_W    = $clog2(MEM_LAT + 2)
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic                   i_mem_uc_vld_w,
    input  logic [ENGID_W-1:0]     i_mem_uc_engid_w,
    input  logic [BANKID_W-1:0]    i_mem_uc_bankid_w,
    input  logic                   i_mem_uc_rd_vld_w,
    input  logic                   i_mem_uc_set_empty_w,
    input  logic                   i_mem_uc_clr_empty_w,
    input  logic                   i_mem_uc_head_vld_w,
    input  logic [PTR_W-1:0]       i_mem_uc_head_ptr_w,
    input  logic                   i_mem_uc_tail_vld_w,
    input  logic [PTR_W-1:0]       i_mem_uc_tail_ptr_w,
    input  logic [BANKS_N*128-1:0] i_mem_dat,
    output logic                   o_wrbk_uc_vld_r,
    output logic [ENGID_W-1:0]     o_wrbk_uc_engid_r,
    output logic                   o_wrbk_uc_set_empty_r,
    output logic                   o_wrbk_uc_clr_empty_r,
    output logic                   o_wrbk_uc_head_vld_r,
    output logic [PTR_W-1:0]       o_wrbk_uc_head_ptr_r,
    output logic                   o_wrbk_uc_tail_vld_r,
    output logic [PTR_W-1:0]       o_wrbk_uc_tail_ptr_r,
    output logic                   o_rsp_vld_r,
    output logic [ENGID_W-1:0]     o_rsp_engid_r,
    output logic [127:0]           o_rsp_dat_r,
    output logic [ENGS_N-1:0]      o_eng_busy_r,
    output logic                   o_err_r
);

    typedef struct packed {
        logic [ENGID_W-1:0]  engid;
        logic [BANKID_W-1:0] bankid;
        logic                rd_vld;
        logic                set_empty;
        logic                clr_empty;
        logic                head_vld;
        logic [PTR_W-1:0]    head_ptr;
        logic                tail_vld;
        logic [PTR_W-1:0]    tail_ptr;
    } uc_t;

    // Pipeline stages 1..MEM_LAT are held at indices 0..MEM_LAT-1.
    logic [MEM_LAT-1:0] stg_vld_d, stg_vld_q;
    uc_t                stg_d [MEM_LAT];
    uc_t                stg_q [MEM_LAT];

    uc_t                uc_in;
    uc_t                last_uc;
    logic               last_vld;
    logic [127:0]       dat_line [BANKS_N];

    uc_t                wrbk_d, wrbk_q;
    logic               wrbk_vld_d, wrbk_vld_q;
    logic               rsp_vld_d, rsp_vld_q;
    logic [127:0]       rsp_dat_d, rsp_dat_q;
    logic               err_d, err_q;

    logic [CNT_W-1:0]   cnt_d [ENGS_N];
    logic [CNT_W-1:0]   cnt_q [ENGS_N];
    logic [ENGS_N-1:0]  busy_d, busy_q;
    logic [ENGS_N-1:0]  inc, dec, underflow;

    // Normalise incoming microcode; a set+clear conflict cancels both updates.
    always_comb begin
        uc_in           = '0;
        uc_in.engid     = i_mem_uc_engid_w;
        uc_in.bankid    = i_mem_uc_bankid_w;
        uc_in.rd_vld    = i_mem_uc_rd_vld_w;
        uc_in.set_empty = i_mem_uc_set_empty_w & ~i_mem_uc_clr_empty_w;
        uc_in.clr_empty = i_mem_uc_clr_empty_w & ~i_mem_uc_set_empty_w;
        uc_in.head_vld  = i_mem_uc_head_vld_w;
        uc_in.head_ptr  = i_mem_uc_head_ptr_w;
        uc_in.tail_vld  = i_mem_uc_tail_vld_w;
        uc_in.tail_ptr  = i_mem_uc_tail_ptr_w;
        err_d = err_q | (i_mem_uc_vld_w & i_mem_uc_set_empty_w & i_mem_uc_clr_empty_w);
    end

    // Shift microcode one stage per edge through the read-latency pipe.
    always_comb begin
        stg_vld_d    = '0;
        stg_vld_d[0] = i_mem_uc_vld_w;
        stg_d[0]     = uc_in;
        for (int i = 1; i < MEM_LAT; i++) begin
            stg_vld_d[i] = stg_vld_q[i-1];
            stg_d[i]     = stg_q[i-1];
        end
    end

    // Split the SRAM bus into per-bank lines for indexing by bank id.
    always_comb begin
        for (int b = 0; b < BANKS_N; b++) begin
            dat_line[b] = i_mem_dat[b*128 +: 128];
        end
    end

    // Form the writeback/response regs from the last stage; payloads zero when idle.
    always_comb begin
        last_vld   = stg_vld_q[MEM_LAT-1];
        last_uc    = stg_q[MEM_LAT-1];
        wrbk_vld_d = last_vld;
        wrbk_d     = '0;
        rsp_vld_d  = 1'b0;
        rsp_dat_d  = '0;
        if (last_vld) begin
            wrbk_d    = last_uc;
            rsp_vld_d = last_uc.rd_vld;
            if (last_uc.rd_vld) begin
                rsp_dat_d = dat_line[last_uc.bankid];
            end
        end
    end

    // Per-engine in-flight counters: +1 on accept, -1 when the writeback slot is replaced.
    always_comb begin
        inc       = '0;
        dec       = '0;
        underflow = '0;
        busy_d    = '0;
        for (int e = 0; e < ENGS_N; e++) begin
            inc[e]       = i_mem_uc_vld_w && (i_mem_uc_engid_w == ENGID_W'(e));
            dec[e]       = wrbk_vld_q && (wrbk_q.engid == ENGID_W'(e));
            underflow[e] = dec[e] && (cnt_q[e] == '0);
            cnt_d[e]     = cnt_q[e] + CNT_W'(inc[e]) - CNT_W'(dec[e]);
            busy_d[e]    = (cnt_d[e] != '0);
        end
    end

    // Control state: stage valids, output regs, counters and sticky error.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            stg_vld_q  <= '0;
            wrbk_vld_q <= 1'b0;
            wrbk_q     <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_dat_q  <= '0;
            busy_q     <= '0;
            err_q      <= 1'b0;
            for (int e = 0; e < ENGS_N; e++) begin
                cnt_q[e] <= '0;
            end
        end else begin
            stg_vld_q  <= stg_vld_d;
            wrbk_vld_q <= wrbk_vld_d;
            wrbk_q     <= wrbk_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_dat_q  <= rsp_dat_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            for (int e = 0; e < ENGS_N; e++) begin
                cnt_q[e] <= cnt_d[e];
            end
        end
    end

    // Stage payloads need no reset: they are only observed behind their valid bits.
    always_ff @(posedge clk) begin
        for (int i = 0; i < MEM_LAT; i++) begin
            stg_q[i] <= stg_d[i];
        end
    end

    assign o_wrbk_uc_vld_r       = wrbk_vld_q;
    assign o_wrbk_uc_engid_r     = wrbk_q.engid;
    assign o_wrbk_uc_set_empty_r = wrbk_q.set_empty;
    assign o_wrbk_uc_clr_empty_r = wrbk_q.clr_empty;
    assign o_wrbk_uc_head_vld_r  = wrbk_q.head_vld;
    assign o_wrbk_uc_head_ptr_r  = wrbk_q.head_ptr;
    assign o_wrbk_uc_tail_vld_r  = wrbk_q.tail_vld;
    assign o_wrbk_uc_tail_ptr_r  = wrbk_q.tail_ptr;
    assign o_rsp_vld_r           = rsp_vld_q;
    assign o_rsp_engid_r         = rsp_vld_q ? wrbk_q.engid : '0;
    assign o_rsp_dat_r           = rsp_dat_q;
    assign o_eng_busy_r          = busy_q;
    assign o_err_r               = err_q;

    a_mem_lat_min: assert property (@(posedge clk) MEM_LAT >= 1)
        else $error("MEM_LAT must be at least 1");
    a_cnt_no_underflow: assert property (@(posedge clk) disable iff (arst) underflow == '0)
        else $error("in-flight counter decremented at zero");

endmodule
